atari_ce_gen: RTL and testbench

- Sits directly downstream of the system PLL and runs on its 28.636360 MHz output (8× NTSC colourburst).
- Synchronises and qualifies the PLL lock signal.
- Sequences the console core reset.
- Derives single-cycle clock enables for the TIA colour clock (3.579545 MHz, /8) and the 6507 CPU (1.193182 MHz, /24), phase-locked to each other.
- Provides a pause request/acknowledge handshake that stops the enables cleanly on a CPU-cycle boundary.

---
 rtl/atari_ce_pkg.sv | 32 +++
 rtl/atari_ce_gen_if.sv | 39 +++
 rtl/atari_ce_gen_sync_bit.sv | 31 +++
 rtl/atari_ce_gen.sv | 167 ++++++++++++++++
 tb/tb_atari_ce_gen.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/atari_ce_pkg.sv
// ---------------------------------------------------------------------------
// atari_ce_pkg
// Shared types and default constants for the Atari clock-enable generator.
//   state_e          : sequencer states (wait for lock, qualify, run, pause)
//   NTSC_COLOR_DIV   : clk cycles per TIA colour-clock enable (28.636/8)
//   NTSC_CPU_DIV     : colour-clock enables per 6507 CPU enable
//   DEFAULT_LOCK_CYCLES : lock qualification length in clk cycles
//   cnt_width()      : counter width helper, never narrower than one bit
// ---------------------------------------------------------------------------
package atari_ce_pkg;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_STABLE = 2'd1,
    S_RUN    = 2'd2,
    S_PAUSE  = 2'd3
  } state_e;

  localparam int NTSC_COLOR_DIV      = 32'sd8;
  localparam int NTSC_CPU_DIV        = 32'sd3;
  localparam int DEFAULT_LOCK_CYCLES = 32'sd1024;

  // Width of a counter spanning 0..n-1; a divide-by-1 still needs one bit.
  function automatic int cnt_width(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/atari_ce_gen_if.sv
// ---------------------------------------------------------------------------
// atari_ce_gen_if
// Bundles the lock / pause handshake / enable signals of atari_ce_gen.
//   pll_locked : PLL lock indication (asynchronous to clk)
//   pause_req  : level request to freeze the console core
//   pause_ack  : enables frozen on a CPU-cycle boundary
//   core_reset : active-high reset to the console core
//   ce_color   : one-clk colour-clock enable
//   ce_cpu     : one-clk CPU enable, always coincident with ce_color
// slave  : the generator side; master : the system / PLL side.
// ---------------------------------------------------------------------------
interface atari_ce_gen_if;

  logic pll_locked;
  logic pause_req;
  logic pause_ack;
  logic core_reset;
  logic ce_color;
  logic ce_cpu;

  modport slave (
    input  pll_locked,
    input  pause_req,
    output pause_ack,
    output core_reset,
    output ce_color,
    output ce_cpu
  );

  modport master (
    output pll_locked,
    output pause_req,
    input  pause_ack,
    input  core_reset,
    input  ce_color,
    input  ce_cpu
  );

endinterface

// File: rtl/atari_ce_gen_sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// Multi-flop synchroniser for a single asynchronous level signal.
//   clk : destination clock
//   rst : asynchronous active-high reset, chain clears to 0
//   d   : asynchronous input
//   q   : synchronised output, SYNC_STAGES clk edges behind d
// ---------------------------------------------------------------------------
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/atari_ce_gen.sv
// ---------------------------------------------------------------------------
// atari_ce_gen
// Runs on the 28.636360 MHz PLL clock. Qualifies PLL lock, sequences the
// console core reset and produces phase-locked single-cycle enables for the
// TIA colour clock (/COLOR_DIV) and the 6507 CPU (/COLOR_DIV*CPU_DIV). A
// pause handshake freezes the enables on a CPU-cycle boundary.
//   clk : PLL output clock
//   rst : asynchronous active-high reset
//   bus : atari_ce_gen_if.slave (pll_locked, pause_req in;
//         pause_ack, core_reset, ce_color, ce_cpu out, all registered)
// ---------------------------------------------------------------------------
module atari_ce_gen
  import atari_ce_pkg::*;
#(
  parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES,
  parameter int COLOR_DIV   = NTSC_COLOR_DIV,
  parameter int CPU_DIV     = NTSC_CPU_DIV,
  parameter int SYNC_STAGES = 32'sd2
) (
  input logic           clk,
  input logic           rst,
  atari_ce_gen_if.slave bus
);

  localparam int SW = cnt_width(LOCK_CYCLES);
  localparam int CW = cnt_width(COLOR_DIV);
  localparam int PW = cnt_width(CPU_DIV);

  localparam logic [SW-1:0] STAB_LAST  = SW'(LOCK_CYCLES - 32'sd1);
  localparam logic [CW-1:0] COLOR_LAST = CW'(COLOR_DIV - 32'sd1);
  localparam logic [PW-1:0] CPU_LAST   = PW'(CPU_DIV - 32'sd1);

  logic          lock_s;
  state_e        state_r;
  state_e        state_s;
  logic [SW-1:0] stab_cnt_r;
  logic [SW-1:0] stab_cnt_s;
  logic [CW-1:0] color_cnt_r;
  logic [CW-1:0] color_cnt_s;
  logic [PW-1:0] cpu_cnt_r;
  logic [PW-1:0] cpu_cnt_s;
  logic          pend_r;
  logic          pend_s;
  logic          core_reset_r;
  logic          core_reset_s;
  logic          ce_color_r;
  logic          ce_color_s;
  logic          ce_cpu_r;
  logic          ce_cpu_s;
  logic          pause_ack_r;
  logic          pause_ack_s;

  sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (lock_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_WAIT;
      stab_cnt_r   <= {SW{1'b0}};
      color_cnt_r  <= {CW{1'b0}};
      cpu_cnt_r    <= {PW{1'b0}};
      pend_r       <= 1'b0;
      core_reset_r <= 1'b1;
      ce_color_r   <= 1'b0;
      ce_cpu_r     <= 1'b0;
      pause_ack_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      stab_cnt_r   <= stab_cnt_s;
      color_cnt_r  <= color_cnt_s;
      cpu_cnt_r    <= cpu_cnt_s;
      pend_r       <= pend_s;
      core_reset_r <= core_reset_s;
      ce_color_r   <= ce_color_s;
      ce_cpu_r     <= ce_cpu_s;
      pause_ack_r  <= pause_ack_s;
    end
  end

  // Next state, lock qualification count, dividers and pause latch.
  always_comb begin
    state_s     = state_r;
    stab_cnt_s  = {SW{1'b0}};
    color_cnt_s = {CW{1'b0}};
    cpu_cnt_s   = {PW{1'b0}};
    pend_s      = 1'b0;
    case (state_r)
      S_WAIT: begin
        if (lock_s) begin
          state_s = S_STABLE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_s = S_WAIT;
        end else if (stab_cnt_r == STAB_LAST) begin
          state_s = S_RUN;
        end else begin
          state_s    = S_STABLE;
          stab_cnt_s = stab_cnt_r + SW'(1'b1);
        end
      end
      S_RUN: begin
        // ce_cpu_r high means the counters have just wrapped to (0,0):
        // the only place a pause may begin, so no enable is cut short.
        if (!lock_s) begin
          state_s = S_WAIT;
        end else if (ce_cpu_r && (bus.pause_req || pend_r)) begin
          state_s = S_PAUSE;
        end else begin
          state_s = S_RUN;
          pend_s  = pend_r | bus.pause_req;
          if (color_cnt_r == COLOR_LAST) begin
            color_cnt_s = {CW{1'b0}};
            if (cpu_cnt_r == CPU_LAST) begin
              cpu_cnt_s = {PW{1'b0}};
            end else begin
              cpu_cnt_s = cpu_cnt_r + PW'(1'b1);
            end
          end else begin
            color_cnt_s = color_cnt_r + CW'(1'b1);
            cpu_cnt_s   = cpu_cnt_r;
          end
        end
      end
      S_PAUSE: begin
        if (!lock_s) begin
          state_s = S_WAIT;
        end else if (!bus.pause_req) begin
          state_s = S_RUN;
        end else begin
          state_s = S_PAUSE;
        end
      end
      default: begin
        state_s = S_WAIT;
      end
    endcase
  end

  // Output values for the next cycle, derived from the transition taken.
  always_comb begin
    core_reset_s = (state_s == S_WAIT) || (state_s == S_STABLE);
    pause_ack_s  = (state_s == S_PAUSE);
    // An enable fires only on a wrap that keeps running; lock loss or a
    // pause taken on the same edge suppresses it.
    ce_color_s   = (state_r == S_RUN) && (state_s == S_RUN) &&
                   (color_cnt_r == COLOR_LAST);
    ce_cpu_s     = (state_r == S_RUN) && (state_s == S_RUN) &&
                   (color_cnt_r == COLOR_LAST) && (cpu_cnt_r == CPU_LAST);
  end

  assign bus.core_reset = core_reset_r;
  assign bus.ce_color   = ce_color_r;
  assign bus.ce_cpu     = ce_cpu_r;
  assign bus.pause_ack  = pause_ack_r;

endmodule

// File: tb/tb_atari_ce_gen.sv
// ---------------------------------------------------------------------------
// tb_atari_ce_gen
// Self-checking bench for atari_ce_gen. A cycle-level reference model built
// from lock history and segment ages predicts all four outputs every cycle;
// directed checks cover latencies, periods and the pause handshake.
// ---------------------------------------------------------------------------
module tb_atari_ce_gen;

  localparam int LOCK = 1024;
  localparam int CDIV = 8;
  localparam int PDIV = 3;
  localparam int SS   = 2;
  localparam int REL  = SS + LOCK + 1;

  localparam int M_OFF   = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic clk;
  logic rst;
  atari_ce_gen_if bus ();

  atari_ce_gen #(
    .LOCK_CYCLES (LOCK),
    .COLOR_DIV   (CDIV),
    .CPU_DIV     (PDIV),
    .SYNC_STAGES (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int          cyc    = 0;
  int          consec = 0;
  int          mode   = M_OFF;
  int          seg    = 0;
  int          pend   = 0;
  logic [SS-1:0] msync = '0;
  logic e_rst, e_col, e_cpu, e_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Predict outputs for cycle cyc from inputs seen at its opening edge.
  task automatic model_edge(input logic p, input logic r, input logic rs);
    int age;
    if (rs) begin
      consec = 0; msync = '0; mode = M_OFF; pend = 0;
    end else begin
      consec = msync[SS-1] ? consec + 1 : 0;
      msync  = {msync[SS-2:0], p};
      if (consec < LOCK + 1) begin
        mode = M_OFF; pend = 0;
      end else if (mode == M_OFF) begin
        mode = M_RUN; seg = cyc; pend = 0;
      end else if (mode == M_RUN) begin
        age = cyc - 1 - seg;
        if (age > 0 && (age % (CDIV * PDIV)) == 0 && (pend != 0 || r)) begin
          mode = M_PAUSE; pend = 0;
        end else if (r) begin
          pend = 1;
        end
      end else if (!r) begin
        mode = M_RUN; seg = cyc;
      end
    end
    age   = cyc - seg;
    e_rst = (mode == M_OFF);
    e_ack = (mode == M_PAUSE);
    e_col = (mode == M_RUN) && age > 0 && (age % CDIV) == 0;
    e_cpu = (mode == M_RUN) && age > 0 && (age % (CDIV * PDIV)) == 0;
  endtask

  task automatic step();
    logic p, r;
    p = bus.pll_locked;
    r = bus.pause_req;
    @(posedge clk);
    cyc++;
    model_edge(p, r, rst);
    @(negedge clk);
    check("core_reset", 32'(bus.core_reset), 32'(e_rst));
    check("ce_color",   32'(bus.ce_color),   32'(e_col));
    check("ce_cpu",     32'(bus.ce_cpu),     32'(e_cpu));
    check("pause_ack",  32'(bus.pause_ack),  32'(e_ack));
  endtask

  task automatic measure_release(input string tag);
    int n;
    n = 0;
    do begin step(); n++; end while (bus.core_reset && n < 2100);
    check(tag, 32'(n), 32'(REL));
  endtask

  task automatic wait_cpu(input string tag);
    int n;
    n = 0;
    do begin step(); n++; end while (!bus.ce_cpu && n < 60);
    check(tag, 32'(bus.ce_cpu), 32'd1);
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    do begin step(); n++; end while (!bus.pause_ack && n < 60);
    check(tag, 32'(bus.pause_ack), 32'd1);
  endtask

  task automatic wait_lock_loss(input string tag);
    int n;
    n = 0;
    do begin step(); n++; end while (!bus.core_reset && n < 10);
    check(tag, 32'(n), 32'(SS + 1));
  endtask

  initial begin
    int n, x, cnt, last_col, last_cpu, hold, leak;

    // 1: reset held with lock present, then release
    rst = 1'b1;
    bus.pll_locked = 1'b1;
    bus.pause_req  = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    measure_release("release_latency");

    // 2: steady run, periods and coincidence
    cnt = 0; last_col = -1; last_cpu = -1;
    repeat (240) begin
      step();
      if (bus.ce_color) begin
        if (last_col >= 0) check("color_period", 32'(cyc - last_col), 32'(CDIV));
        last_col = cyc;
      end
      if (bus.ce_cpu) begin
        cnt++;
        check("cpu_with_color", 32'(bus.ce_color), 32'd1);
        if (last_cpu >= 0) check("cpu_period", 32'(cyc - last_cpu), 32'(CDIV * PDIV));
        last_cpu = cyc;
      end
    end
    check("cpu_pulses_240", 32'(cnt), 32'd10);

    // 4: pause raised 5 cycles after a ce_cpu
    wait_cpu("cpu_before_pause");
    x = cyc;
    repeat (5) step();
    bus.pause_req = 1'b1;
    wait_ack("ack_rises");
    check("ack_rise_cycle", 32'(cyc - x), 32'(CDIV * PDIV + 1));
    hold = $urandom_range(2, 12);
    leak = 0;
    repeat (hold) begin
      step();
      if (bus.ce_color) leak++;
    end
    check("color_in_pause", 32'(leak), 32'd0);
    bus.pause_req = 1'b0;
    step();
    check("ack_falls", 32'(bus.pause_ack), 32'd0);
    n = 0;
    do begin step(); n++; end while (!bus.ce_color && n < 40);
    check("color_after_resume", 32'(n), 32'(CDIV));

    // short pause pulse is latched and honoured for exactly one cycle
    wait_cpu("cpu_before_pulse");
    repeat ($urandom_range(3, 15)) step();
    bus.pause_req = 1'b1;
    step();
    bus.pause_req = 1'b0;
    cnt = 0;
    repeat (40) begin
      step();
      if (bus.pause_ack) cnt++;
    end
    check("pulse_ack_cycles", 32'(cnt), 32'd1);

    // random pause traffic against the model
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) bus.pause_req = ~bus.pause_req;
      step();
    end
    bus.pause_req = 1'b0;
    repeat (30) step();

    // 5: lock lost in RUN, then full re-sequencing
    repeat ($urandom_range(0, 23)) step();
    bus.pll_locked = 1'b0;
    wait_lock_loss("loss_run_latency");
    repeat ($urandom_range(1, 5)) step();
    bus.pll_locked = 1'b1;
    measure_release("reseq_after_run_loss");

    // 5: lock lost in PAUSE
    bus.pause_req = 1'b1;
    wait_ack("ack_before_loss");
    bus.pll_locked = 1'b0;
    wait_lock_loss("loss_pause_latency");
    check("ack_after_loss", 32'(bus.pause_ack), 32'd0);
    repeat (3) step();
    bus.pll_locked = 1'b1;
    measure_release("reseq_after_pause_loss");
    repeat (40) step();
    bus.pause_req = 1'b0;
    repeat (10) step();

    // 3: lock glitch part-way through qualification
    bus.pll_locked = 1'b0;
    repeat (6) step();
    bus.pll_locked = 1'b1;
    leak = 0;
    repeat (503) begin
      step();
      if (!bus.core_reset) leak++;
    end
    bus.pll_locked = 1'b0;
    repeat (3) begin
      step();
      if (!bus.core_reset) leak++;
    end
    check("no_early_release", 32'(leak), 32'd0);
    bus.pll_locked = 1'b1;
    measure_release("reseq_after_glitch");

    // 6: asynchronous reset on a ce_cpu cycle
    wait_cpu("cpu_before_arst");
    #2 rst = 1'b1;
    #1;
    check("arst_core_reset", 32'(bus.core_reset), 32'd1);
    check("arst_ce_color",   32'(bus.ce_color),   32'd0);
    check("arst_ce_cpu",     32'(bus.ce_cpu),     32'd0);
    repeat (3) step();
    rst = 1'b0;
    measure_release("release_after_arst");

    // 6: asynchronous reset while paused
    bus.pause_req = 1'b1;
    wait_ack("ack_before_arst");
    #2 rst = 1'b1;
    #1;
    check("arst_pause_ack",   32'(bus.pause_ack),  32'd0);
    check("arst_core_reset2", 32'(bus.core_reset), 32'd1);
    bus.pause_req = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    measure_release("release_after_arst2");
    repeat (30) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
